// File: rtl/poker_types.sv
// poker_types: types and constants shared by the card-handling blocks.
//   card_t          - one card as a 6-bit deck index (0..51)
//   dealer_cmd_t    - phase commands from the game FSM to dealer_ctrl
//   dealer_phase_t  - current hand phase reported by dealer_ctrl
//   helper functions: command legality, phase reached on completion,
//                     number of deck draws for a street (burn included)
package poker_types;

    typedef logic [5:0] card_t;

    localparam int BOARD_SLOTS  = 5;
    localparam int FLOP_DRAWS   = 4;  // burn + 3 board cards
    localparam int STREET_DRAWS = 2;  // burn + 1 board card

    typedef enum logic [1:0] {
        CMD_NEW_HAND = 2'd0,
        CMD_FLOP     = 2'd1,
        CMD_TURN     = 2'd2,
        CMD_RIVER    = 2'd3
    } dealer_cmd_t;

    typedef enum logic [2:0] {
        PH_NO_HAND = 3'd0,
        PH_PREFLOP = 3'd1,
        PH_FLOP    = 3'd2,
        PH_TURN    = 3'd3,
        PH_RIVER   = 3'd4
    } dealer_phase_t;

    // NEW_HAND restarts from anywhere; each street needs the previous one.
    function automatic logic cmd_legal(input dealer_cmd_t c, input dealer_phase_t p);
        case (c)
            CMD_NEW_HAND: return 1'b1;
            CMD_FLOP:     return p == PH_PREFLOP;
            CMD_TURN:     return p == PH_FLOP;
            CMD_RIVER:    return p == PH_TURN;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic dealer_phase_t phase_after(input dealer_cmd_t c);
        case (c)
            CMD_NEW_HAND: return PH_PREFLOP;
            CMD_FLOP:     return PH_FLOP;
            CMD_TURN:     return PH_TURN;
            CMD_RIVER:    return PH_RIVER;
            default:      return PH_NO_HAND;
        endcase
    endfunction

    function automatic logic [4:0] street_draws(input dealer_cmd_t c);
        return (c == CMD_FLOP) ? 5'(FLOP_DRAWS) : 5'(STREET_DRAWS);
    endfunction

endpackage

// File: rtl/dealer_ctrl.sv
// dealer_ctrl: sequences card_deck (shuffle/draw pulses) and turns the
// shuffled deck into a hold'em hand.
//   clk, reset               - clock, asynchronous active-high reset
//   cmd_valid/cmd/cmd_ready  - phase command handshake (ready only in IDLE)
//   deck_start_shuffle       - one-cycle shuffle request to card_deck
//   deck_draw_card           - one-cycle draw request to card_deck
//   deck_ready/deck_top_card - card_deck status and current top card
//   card_valid/card_out      - emitted card strobe and value
//   card_is_board/card_dest/card_slot - card tag (player+slot, or board slot)
//   board/board_count        - community cards and number of valid slots
//   phase                    - current hand phase
//   done/cmd_err             - completion / illegal-command pulses
module dealer_ctrl
    import poker_types::*;
#(
    parameter int NUM_PLAYERS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    input  dealer_cmd_t                 cmd,
    output logic                        cmd_ready,
    output logic                        deck_start_shuffle,
    output logic                        deck_draw_card,
    input  logic                        deck_ready,
    input  card_t                       deck_top_card,
    output logic                        card_valid,
    output card_t                       card_out,
    output logic                        card_is_board,
    output logic [2:0]                  card_dest,
    output logic                        card_slot,
    output card_t [BOARD_SLOTS-1:0]     board,
    output logic [2:0]                  board_count,
    output dealer_phase_t               phase,
    output logic                        done,
    output logic                        cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHUF_REQ,
        S_SHUF_GAP,
        S_SHUF_WAIT,
        S_DRAW,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    dealer_phase_t           phase_q;
    dealer_cmd_t             op_q;          // command being executed
    logic [4:0]              draw_cnt_q;    // draws still to make
    logic                    first_q;       // next draw is the first of the command
    logic [2:0]              player_q;      // hole-deal player index
    logic                    slot_q;        // hole-deal slot
    card_t                   card_q;        // card latched in DRAW
    card_t [BOARD_SLOTS-1:0] board_q;
    logic [2:0]              board_count_q;
    logic                    cmd_err_q;

    logic accept;
    logic legal;
    logic is_street;
    logic burn;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign legal     = cmd_legal(cmd, phase_q);
    assign is_street = (op_q != CMD_NEW_HAND);
    // The first draw of every street goes to the muck.
    assign burn      = is_street && first_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and simulation order cannot matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: next-state starts from a default so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && legal) begin
                    state_d = (cmd == CMD_NEW_HAND) ? S_SHUF_REQ : S_DRAW;
                end
            end
            S_SHUF_REQ:  state_d = S_SHUF_GAP;
            // card_deck drops ready here; its stale ready must not be seen.
            S_SHUF_GAP:  state_d = S_SHUF_WAIT;
            S_SHUF_WAIT: if (deck_ready) state_d = S_DRAW;
            S_DRAW:      if (deck_ready) state_d = S_SETTLE;
            S_SETTLE:    state_d = (draw_cnt_q == 5'd1) ? S_DONE : S_DRAW;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // NOTE: the board is only five registers, so it is reset with the rest
    // of the datapath; a large RAM would be left unreset instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PH_NO_HAND;
            op_q          <= CMD_NEW_HAND;
            draw_cnt_q    <= '0;
            first_q       <= 1'b0;
            player_q      <= '0;
            slot_q        <= 1'b0;
            card_q        <= '0;
            board_q       <= '0;
            board_count_q <= '0;
            cmd_err_q     <= 1'b0;
        end else begin
            // Illegal commands are accepted but change nothing except cmd_err.
            cmd_err_q <= accept && !legal;
            case (state_q)
                S_IDLE: begin
                    if (accept && legal) begin
                        op_q    <= cmd;
                        first_q <= 1'b1;
                        if (cmd == CMD_NEW_HAND) begin
                            board_count_q <= '0;
                            player_q      <= '0;
                            slot_q        <= 1'b0;
                        end else begin
                            draw_cnt_q <= street_draws(cmd);
                        end
                    end
                end
                S_SHUF_WAIT: begin
                    if (deck_ready) draw_cnt_q <= 5'(2 * NUM_PLAYERS);
                end
                S_DRAW: begin
                    if (deck_ready) card_q <= deck_top_card;
                end
                S_SETTLE: begin
                    draw_cnt_q <= draw_cnt_q - 5'd1;
                    first_q    <= 1'b0;
                    if (!is_street) begin
                        // Round-robin: all players get slot 0, then slot 1.
                        if (player_q == 3'(NUM_PLAYERS - 1)) begin
                            player_q <= '0;
                            slot_q   <= 1'b1;
                        end else begin
                            player_q <= player_q + 3'd1;
                        end
                    end else if (!burn && (board_count_q < 3'(BOARD_SLOTS))) begin
                        board_q[board_count_q] <= card_q;
                        board_count_q          <= board_count_q + 3'd1;
                    end
                end
                S_DONE: phase_q <= phase_after(op_q);
                default: ;
            endcase
        end
    end

    assign cmd_ready          = (state_q == S_IDLE);
    assign deck_start_shuffle = (state_q == S_SHUF_REQ);
    assign deck_draw_card     = (state_q == S_DRAW) && deck_ready;
    assign card_valid         = (state_q == S_SETTLE) && !burn;
    assign card_out           = card_q;
    assign card_is_board      = is_street;
    // For board cards board_count still points at the slot being written.
    assign card_dest          = is_street ? board_count_q : player_q;
    assign card_slot          = is_street ? 1'b0 : slot_q;
    assign board              = board_q;
    assign board_count        = board_count_q;
    assign phase              = phase_q;
    assign done               = (state_q == S_DONE);
    assign cmd_err            = cmd_err_q;

endmodule

// File: tb/tb_dealer_ctrl.sv
// tb_dealer_ctrl: scoreboard bench for dealer_ctrl. Two instances (4 and 8
// players) each run against a small card_deck stub whose top card counts
// 0,1,2,... after every shuffle.
module tb_dealer_ctrl;
    import poker_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    dealer_cmd_t   cmd;
    logic          cmd_valid   [2];
    logic          cmd_ready   [2];
    logic          start_w     [2];
    logic          draw_w      [2];
    logic          deck_ready  [2];
    logic          deck_rdy_q  [2];
    card_t         top_q       [2];
    logic          card_valid_w[2];
    card_t         card_w      [2];
    logic          is_board_w  [2];
    logic [2:0]    dest_w      [2];
    logic          slot_w      [2];
    card_t [4:0]   board_w     [2];
    logic [2:0]    bcnt_w      [2];
    dealer_phase_t phase_w     [2];
    logic          done_w      [2];
    logic          err_w       [2];
    logic          stall;

    assign deck_ready[0] = deck_rdy_q[0] && !stall;
    assign deck_ready[1] = deck_rdy_q[1];

    dealer_ctrl #(.NUM_PLAYERS(4)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd(cmd),
        .cmd_ready(cmd_ready[0]), .deck_start_shuffle(start_w[0]),
        .deck_draw_card(draw_w[0]), .deck_ready(deck_ready[0]),
        .deck_top_card(top_q[0]), .card_valid(card_valid_w[0]),
        .card_out(card_w[0]), .card_is_board(is_board_w[0]),
        .card_dest(dest_w[0]), .card_slot(slot_w[0]), .board(board_w[0]),
        .board_count(bcnt_w[0]), .phase(phase_w[0]), .done(done_w[0]),
        .cmd_err(err_w[0])
    );

    dealer_ctrl #(.NUM_PLAYERS(8)) dut8 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd(cmd),
        .cmd_ready(cmd_ready[1]), .deck_start_shuffle(start_w[1]),
        .deck_draw_card(draw_w[1]), .deck_ready(deck_ready[1]),
        .deck_top_card(top_q[1]), .card_valid(card_valid_w[1]),
        .card_out(card_w[1]), .card_is_board(is_board_w[1]),
        .card_dest(dest_w[1]), .card_slot(slot_w[1]), .board(board_w[1]),
        .board_count(bcnt_w[1]), .phase(phase_w[1]), .done(done_w[1]),
        .cmd_err(err_w[1])
    );

    typedef struct {
        card_t      card;
        logic       is_board;
        logic [2:0] dest;
        logic       slot;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int total = 0;
    int bad   = 0;
    int shuf_cnt[2] = '{0, 0};
    int draw_cnt[2] = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int err_cnt [2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int u, input int c, input logic b, input int d, input int s);
        exp_t e;
        e.card = card_t'(c);
        e.is_board = b;
        e.dest = 3'(d);
        e.slot = s[0];
        if (u == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // card_deck stub: ready returns 3 cycles after a shuffle, top restarts at 0
    // and advances on each draw.
    initial begin
        int gap[2];
        logic s[2];
        logic d[2];
        gap = '{0, 0};
        deck_rdy_q = '{1'b0, 1'b0};
        top_q = '{6'd0, 6'd0};
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                s[u] = start_w[u];
                d[u] = draw_w[u];
            end
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                if (reset) begin
                    deck_rdy_q[u] = 1'b0;
                    top_q[u] = '0;
                    gap[u] = 0;
                end else if (s[u]) begin
                    deck_rdy_q[u] = 1'b0;
                    top_q[u] = '0;
                    gap[u] = 3;
                end else begin
                    if (gap[u] > 0) begin
                        gap[u]--;
                        if (gap[u] == 0) deck_rdy_q[u] = 1'b1;
                    end
                    if (d[u]) top_q[u] = top_q[u] + 6'd1;
                end
            end
        end
    end

    // Monitor: counts pulses and pops the scoreboard on every emitted card.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int u = 0; u < 2; u++) begin
                    if (start_w[u]) shuf_cnt[u]++;
                    if (draw_w[u])  draw_cnt[u]++;
                    if (done_w[u])  done_cnt[u]++;
                    if (err_w[u])   err_cnt[u]++;
                    if (card_valid_w[u]) begin
                        if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_card u%0d: got card %0d expected none", u, card_w[u]);
                        end else begin
                            e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
                            check($sformatf("card_u%0d", u), card_w[u], e.card);
                            check($sformatf("is_board_u%0d", u), is_board_w[u], e.is_board);
                            check($sformatf("dest_u%0d", u), dest_w[u], e.dest);
                            check($sformatf("slot_u%0d", u), slot_w[u], e.slot);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic m0, input logic m1, input dealer_cmd_t c);
        @(negedge clk);
        if (m0) check("cmd_ready_u0", cmd_ready[0], 1);
        if (m1) check("cmd_ready_u1", cmd_ready[1], 1);
        cmd = c;
        cmd_valid[0] = m0;
        cmd_valid[1] = m1;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        cmd_valid[1] = 1'b0;
    endtask

    // Counts cycles from the accept edge; cycle 1 is the first state after IDLE.
    task automatic wait_done(input int u, input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done_w[u]) begin
                cyc = i;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL done_timeout u%0d: got no done expected done within %0d cycles", u, limit);
    endtask

    initial begin
        int c;
        int b_shuf[2];
        int b_draw[2];
        int b_done[2];
        int b_err;
        reset = 1'b1;
        stall = 1'b0;
        cmd = CMD_NEW_HAND;
        cmd_valid = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready[0], 1);
        check("rst_phase", phase_w[0], PH_NO_HAND);
        check("rst_board_count", bcnt_w[0], 0);
        check("rst_card_valid", card_valid_w[0], 0);

        // Reset in the middle of a NEW_HAND shuffle.
        b_done[0] = done_cnt[0];
        issue(1'b1, 1'b0, CMD_NEW_HAND);
        @(negedge clk);
        check("shuf_pulse_before_reset", start_w[0], 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready[0], 1);
        check("midrst_phase", phase_w[0], PH_NO_HAND);
        check("midrst_board_count", bcnt_w[0], 0);
        check("midrst_shuffle", start_w[0], 0);
        check("midrst_draw", draw_w[0], 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_no_done", done_cnt[0] - b_done[0], 0);

        // NEW_HAND on both instances.
        for (int i = 0; i < 8; i++)  push(0, i, 1'b0, i % 4, i / 4);
        for (int i = 0; i < 16; i++) push(1, i, 1'b0, i % 8, i / 8);
        for (int u = 0; u < 2; u++) begin
            b_shuf[u] = shuf_cnt[u];
            b_draw[u] = draw_cnt[u];
            b_done[u] = done_cnt[u];
        end
        issue(1'b1, 1'b1, CMD_NEW_HAND);
        wait_done(0, 200, c);
        wait_done(1, 200, c);
        @(negedge clk);
        check("nh_shuffles_u0", shuf_cnt[0] - b_shuf[0], 1);
        check("nh_shuffles_u1", shuf_cnt[1] - b_shuf[1], 1);
        check("nh_draws_u0", draw_cnt[0] - b_draw[0], 8);
        check("nh_draws_u1", draw_cnt[1] - b_draw[1], 16);
        check("nh_done_u0", done_cnt[0] - b_done[0], 1);
        check("nh_done_u1", done_cnt[1] - b_done[1], 1);
        check("nh_phase_u0", phase_w[0], PH_PREFLOP);
        check("nh_phase_u1", phase_w[1], PH_PREFLOP);

        // Illegal TURN in PREFLOP.
        b_draw[0] = draw_cnt[0];
        b_shuf[0] = shuf_cnt[0];
        b_done[0] = done_cnt[0];
        b_err = err_cnt[0];
        issue(1'b1, 1'b0, CMD_TURN);
        @(negedge clk);
        check("err_pulse", err_w[0], 1);
        @(negedge clk);
        check("err_one_cycle", err_w[0], 0);
        repeat (2) @(negedge clk);
        check("err_count", err_cnt[0] - b_err, 1);
        check("err_no_draw", draw_cnt[0] - b_draw[0], 0);
        check("err_no_shuffle", shuf_cnt[0] - b_shuf[0], 0);
        check("err_no_done", done_cnt[0] - b_done[0], 0);
        check("err_phase", phase_w[0], PH_PREFLOP);
        check("err_ready", cmd_ready[0], 1);

        // FLOP: burn 8, board 9,10,11.
        push(0, 9, 1'b1, 0, 0);
        push(0, 10, 1'b1, 1, 0);
        push(0, 11, 1'b1, 2, 0);
        b_draw[0] = draw_cnt[0];
        issue(1'b1, 1'b0, CMD_FLOP);
        wait_done(0, 100, c);
        check("flop_latency", c, 9);
        @(negedge clk);
        check("flop_draws", draw_cnt[0] - b_draw[0], 4);
        check("flop_board_count", bcnt_w[0], 3);
        check("flop_phase", phase_w[0], PH_FLOP);

        // TURN: burn 12, board 13.
        push(0, 13, 1'b1, 3, 0);
        issue(1'b1, 1'b0, CMD_TURN);
        wait_done(0, 100, c);
        check("turn_latency", c, 5);
        @(negedge clk);
        check("turn_board_count", bcnt_w[0], 4);

        // RIVER: burn 14, board 15.
        push(0, 15, 1'b1, 4, 0);
        issue(1'b1, 1'b0, CMD_RIVER);
        wait_done(0, 100, c);
        check("river_latency", c, 5);
        @(negedge clk);
        check("river_board_count", bcnt_w[0], 5);
        check("river_phase", phase_w[0], PH_RIVER);
        check("board0", board_w[0][0], 9);
        check("board1", board_w[0][1], 10);
        check("board2", board_w[0][2], 11);
        check("board3", board_w[0][3], 13);
        check("board4", board_w[0][4], 15);

        // Second NEW_HAND from RIVER.
        for (int i = 0; i < 8; i++) push(0, i, 1'b0, i % 4, i / 4);
        issue(1'b1, 1'b0, CMD_NEW_HAND);
        @(negedge clk);
        check("nh2_board_count", bcnt_w[0], 0);
        wait_done(0, 200, c);
        @(negedge clk);
        check("nh2_phase", phase_w[0], PH_PREFLOP);

        // FLOP with deck_ready held low for 5 cycles at the second draw.
        push(0, 9, 1'b1, 0, 0);
        push(0, 10, 1'b1, 1, 0);
        push(0, 11, 1'b1, 2, 0);
        b_draw[0] = draw_cnt[0];
        issue(1'b1, 1'b0, CMD_FLOP);
        fork
            begin
                repeat (2) @(posedge clk);
                #1;
                stall = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_no_draw", draw_w[0], 0);
                end
                @(posedge clk);
                #1;
                stall = 1'b0;
            end
            begin
                wait_done(0, 100, c);
            end
        join
        check("stall_latency", c, 14);
        @(negedge clk);
        check("stall_draws", draw_cnt[0] - b_draw[0], 4);
        check("stall_board_count", bcnt_w[0], 3);

        repeat (2) @(negedge clk);
        check("sb_left_u0", sb0.size(), 0);
        check("sb_left_u1", sb1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dealer_ctrl.md
Name: dealer_ctrl

Overview:
- Sequencing controller for `card_deck`: drives its shuffle/draw handshake and turns the shuffled deck into a hold'em hand.
- Accepts phase commands from the game FSM: NEW_HAND, FLOP, TURN, RIVER.
- Emits a tagged card stream for hole cards and keeps a board register for the community cards.
- Sits between the game FSM and `card_deck`; it is the only agent allowed to pulse the deck's `start_shuffle` and `draw_card`.

Parameters:
- NUM_PLAYERS, 4, seated players, legal range 2..8; sets hole-deal round-robin length.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd  in  2  dealer_cmd_t: 0 NEW_HAND, 1 FLOP, 2 TURN, 3 RIVER
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready at a rising edge
- deck_start_shuffle  out  1  one-cycle pulse to card_deck
- deck_draw_card  out  1  one-cycle pulse to card_deck
- deck_ready  in  1  card_deck shuffled / top card valid
- deck_top_card  in  card_t  card_deck current top card
- card_valid  out  1  one-cycle strobe, emitted card valid
- card_out  out  card_t  emitted card
- card_is_board  out  1  0 = hole card, 1 = board card
- card_dest  out  3  hole: player index; board: slot 0..4
- card_slot  out  1  hole-card slot 0/1; 0 for board cards
- board  out  5 x card_t  community cards, slot order
- board_count  out  3  valid board slots, 0..5
- phase  out  3  dealer_phase_t: NO_HAND, PREFLOP, FLOP, TURN, RIVER
- done  out  1  one-cycle pulse on command completion
- cmd_err  out  1  one-cycle pulse on illegal command

Behaviour:
- Reset values (asynchronous): state IDLE, phase NO_HAND, board all zero, board_count 0, all strobes/pulses 0, card_out 0, card_dest 0, card_slot 0. Reset mid-operation abandons the command with no done; `card_deck` is reset by the same reset.
- Command legality:
  - NEW_HAND is legal in any phase.
  - FLOP is legal only in PREFLOP, TURN only in FLOP, RIVER only in TURN.
  - An illegal command is still accepted: cmd_err pulses the next cycle, state stays IDLE, nothing else changes.
- FSM states: IDLE, SHUF_REQ, SHUF_GAP, SHUF_WAIT, DRAW, SETTLE, DONE.
  - IDLE -> SHUF_REQ on an accepted NEW_HAND. board_count is cleared to 0 on that edge.
  - IDLE -> DRAW on an accepted legal FLOP/TURN/RIVER. The draw counter is loaded with 4 for FLOP, 2 for TURN, 2 for RIVER.
  - SHUF_REQ: deck_start_shuffle = 1 for exactly one cycle, then SHUF_GAP.
  - SHUF_GAP: one cycle in which deck_ready is ignored (the deck drops ready here), then SHUF_WAIT.
  - SHUF_WAIT -> DRAW when deck_ready = 1. Draw counter = 2*NUM_PLAYERS.
  - DRAW: if deck_ready = 0, stall with no pulse. Otherwise latch deck_top_card, pulse deck_draw_card, go to SETTLE.
  - SETTLE: one cycle.
    - card_valid is asserted here with the latched card, except for burn draws.
    - Decrement the draw counter; go to DRAW if it is nonzero, else DONE.
  - DONE: done = 1, phase advances (NO_HAND/any -> PREFLOP for NEW_HAND; then FLOP, TURN, RIVER), then IDLE.
- Hole order: draw i (0-based) goes to player i mod NUM_PLAYERS, slot i / NUM_PLAYERS.
- Board draws:
  - The first draw of FLOP, TURN and RIVER is a burn: drawn from the deck but never emitted.
  - Each subsequent draw writes board[board_count] in SETTLE and increments board_count; card_is_board = 1, card_dest = written slot.
- Throughput: one card per 2 cycles with the deck ready. FLOP from accept to done = 9 cycles (4 draw/settle pairs + DONE).
- cmd_valid while busy is not sampled; cmd_ready = 0.
- A deck_ready drop during DRAW/SETTLE causes no extra or lost draw. A drop in SETTLE only delays the next DRAW.

Decomposition:
- Add to `poker_types` package:
  - dealer_cmd_t and dealer_phase_t enums.
  - Constants BOARD_SLOTS = 5, FLOP_DRAWS = 4, STREET_DRAWS = 2.
- card_t is reused from the package.
- Single module, no sub-module. The FSM, draw counter, hole index counter and board register file are all local.

Test Plan:
- Reset check: assert reset mid-NEW_HAND -> next cycle state IDLE, phase NO_HAND, board_count 0, no deck pulses, cmd_ready 1.
- NEW_HAND, NUM_PLAYERS=4, stub deck returning top cards 0,1,2,… after ready:
  - deck_start_shuffle pulses once, exactly 8 deck_draw_card pulses.
  - Emitted (card, player, slot) = (0,0,0)(1,1,0)(2,2,0)(3,3,0)(4,0,1)…(7,3,1).
  - done pulses once, phase = PREFLOP.
- FLOP, TURN, RIVER in sequence:
  - Cards 8, 12 and 14 are burned (never emitted).
  - board = {9,10,11,13,15}, board_count = 5, phase = RIVER.
  - FLOP done exactly 9 cycles after accept.
- Illegal order: TURN issued in PREFLOP -> cmd_err 1 cycle, no deck pulses, phase remains PREFLOP. A second NEW_HAND from RIVER is accepted and board_count returns to 0.
- Stall: hold deck_ready = 0 for 5 cycles during the FLOP's second draw -> no deck_draw_card during the stall, the same card sequence resumes, done is delayed by exactly 5 cycles.
- NUM_PLAYERS=8 NEW_HAND -> 16 draws, last hole card goes to player 7 slot 1, done pulses once.
